// File: rtl/rx_mem.sv
// Receive-side ping-pong frame store: the radio writes into one bank while the HDMI
// side streams the other, and the banks swap only during vertical blanking.
module rx_mem #(
    parameter int unsigned DEPTH = 38400,
    parameter int unsigned AW    = 16,
    parameter int unsigned DIV   = 5
) (
    input  logic          Cclk,
    input  logic          rstn,
    input  logic          RecEn,
    input  logic          RecValid,
    input  logic [11:0]   RecData,
    input  logic [AW-1:0] RecAdd,
    input  logic          RecFrame,
    output logic          FrameDone,
    output logic          FrameErr,
    output logic [AW-1:0] MissCnt,
    output logic          DropFrm,
    output logic          AddrErr,
    input  logic          HVsync,
    input  logic          HMemRead,
    output logic [23:0]   HDMIdata,
    output logic          PixEn
);

    localparam int unsigned MW = $clog2(2 * DEPTH);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [11:0] mem [2*DEPTH];

    logic          wbank_q, wbank_d;
    logic          pending_q, pending_d;
    logic [AW:0]   wcnt_q, wcnt_d;
    logic          drop_q, drop_d;
    logic          addr_err_q, addr_err_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW-1:0] miss_q, miss_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pix_en_q, pix_en_d;
    logic [AW-1:0] hradd_q, hradd_d;
    logic          hmr_q;
    logic          fetch_q;
    logic [23:0]   hdmi_q, hdmi_d;
    logic [11:0]   rd_data_q;

    logic          acc_c;
    logic          in_range_c;
    logic          wr_en_c;
    logic          frame_end_c;
    logic          fetch_c;
    logic [MW-1:0] wr_idx_c;
    logic [MW-1:0] rd_idx_c;

    // Write side: frame bookkeeping, drop/pending control and bank swap
    always_comb begin
        wbank_d    = wbank_q;
        pending_d  = pending_q;
        wcnt_d     = wcnt_q;
        drop_d     = drop_q;
        addr_err_d = addr_err_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        miss_d     = miss_q;

        acc_c      = RecEn && RecValid;
        in_range_c = {1'b0, RecAdd} < DEPTH_W;

        if (acc_c && RecFrame) begin
            drop_d     = pending_q;
            addr_err_d = 1'b0;
            if (!pending_q) begin
                wcnt_d = (AW + 1)'(1);
            end
        end
        if (acc_c && !in_range_c) begin
            addr_err_d = 1'b1;
        end

        wr_en_c = acc_c && !drop_d && in_range_c;
        if (wr_en_c && !RecFrame && (wcnt_q != DEPTH_W)) begin
            wcnt_d = wcnt_q + (AW + 1)'(1);
        end

        frame_end_c = acc_c && !drop_d && (RecAdd == LAST_A);
        if (frame_end_c) begin
            if (wcnt_d == DEPTH_W) begin
                done_d    = 1'b1;
                pending_d = 1'b1;
            end else begin
                err_d  = 1'b1;
                miss_d = AW'(DEPTH_W - wcnt_d);
            end
        end

        // A same-cycle write still targets the old bank; Pending blocks new frames meanwhile
        if (pending_q && !HVsync) begin
            wbank_d   = ~wbank_q;
            pending_d = 1'b0;
        end

        wr_idx_c = MW'({1'b0, RecAdd} + (wbank_q ? DEPTH_W : (AW + 1)'(0)));
    end

    // Read side: pixel slot timing, address pointer and output formatting
    always_comb begin
        cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        pix_en_d = (cnt_d == '0);
        hradd_d  = hradd_q;
        hdmi_d   = hdmi_q;

        fetch_c = pix_en_q && HMemRead;
        if (fetch_c) begin
            hradd_d = (hradd_q == LAST_A) ? '0 : hradd_q + AW'(1);
        end
        if (!HVsync) begin
            hradd_d = '0;
        end

        if (fetch_q) begin
            hdmi_d = {rd_data_q[11:8], 4'hf, rd_data_q[7:4], 4'hf, rd_data_q[3:0], 4'hf};
        end else if (!hmr_q) begin
            hdmi_d = '0;
        end

        rd_idx_c = MW'({1'b0, hradd_q} + (wbank_q ? (AW + 1)'(0) : DEPTH_W));
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            wbank_q    <= 1'b0;
            pending_q  <= 1'b0;
            wcnt_q     <= '0;
            drop_q     <= 1'b0;
            addr_err_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            miss_q     <= '0;
            cnt_q      <= '0;
            pix_en_q   <= 1'b0;
            hradd_q    <= '0;
            hmr_q      <= 1'b0;
            fetch_q    <= 1'b0;
            hdmi_q     <= '0;
        end else begin
            wbank_q    <= wbank_d;
            pending_q  <= pending_d;
            wcnt_q     <= wcnt_d;
            drop_q     <= drop_d;
            addr_err_q <= addr_err_d;
            done_q     <= done_d;
            err_q      <= err_d;
            miss_q     <= miss_d;
            cnt_q      <= cnt_d;
            pix_en_q   <= pix_en_d;
            hradd_q    <= hradd_d;
            hmr_q      <= HMemRead;
            fetch_q    <= fetch_c;
            hdmi_q     <= hdmi_d;
        end
    end

    // Frame memory: both banks in one array, bank select folded into the index
    always_ff @(posedge Cclk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= RecData;
        end
        if (fetch_c) begin
            rd_data_q <= mem[rd_idx_c];
        end
    end

    assign FrameDone = done_q;
    assign FrameErr  = err_q;
    assign MissCnt   = miss_q;
    assign DropFrm   = drop_q;
    assign AddrErr   = addr_err_q;
    assign HDMIdata  = hdmi_q;
    assign PixEn     = pix_en_q;

endmodule

// File: tb/tb_rx_mem.sv
// Directed bench for rx_mem with a 16-word frame: completion, errors, drops,
// out-of-range addresses, swap timing and mid-frame reset.
module tb_rx_mem;

    logic        Cclk = 1'b0;
    logic        rstn;
    logic        RecEn, RecValid, RecFrame;
    logic [11:0] RecData;
    logic [15:0] RecAdd;
    logic        FrameDone, FrameErr, DropFrm, AddrErr;
    logic [15:0] MissCnt;
    logic        HVsync, HMemRead;
    logic [23:0] HDMIdata;
    logic        PixEn;

    int errors = 0;
    int checks = 0;
    logic [23:0] px [16];

    rx_mem #(.DEPTH(16), .AW(16), .DIV(5)) dut (
        .Cclk(Cclk), .rstn(rstn), .RecEn(RecEn), .RecValid(RecValid),
        .RecData(RecData), .RecAdd(RecAdd), .RecFrame(RecFrame),
        .FrameDone(FrameDone), .FrameErr(FrameErr), .MissCnt(MissCnt),
        .DropFrm(DropFrm), .AddrErr(AddrErr), .HVsync(HVsync),
        .HMemRead(HMemRead), .HDMIdata(HDMIdata), .PixEn(PixEn)
    );

    always #5 Cclk = ~Cclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Cclk);
        #1;
    endtask

    function automatic logic [11:0] pat(input int seed, input int a);
        if (seed == 0) return 12'(a * 'h111);
        return 12'((seed << 8) | (a << 4) | (15 - a));
    endfunction

    function automatic logic [23:0] exp_px(input logic [11:0] w);
        return {w[11:8], 4'hf, w[7:4], 4'hf, w[3:0], 4'hf};
    endfunction

    task automatic send(input int a, input logic [11:0] d, input logic f);
        RecValid = 1'b1;
        RecAdd   = 16'(a);
        RecData  = d;
        RecFrame = f;
        tick();
        RecValid = 1'b0;
        RecFrame = 1'b0;
    endtask

    task automatic send_range(input int seed, input int lo, input int hi, input logic [15:0] skip);
        for (int a = lo; a <= hi; a++) begin
            if (!skip[a]) send(a, pat(seed, a), a == 0);
        end
    endtask

    task automatic vblank();
        HVsync = 1'b0;
        repeat (3) tick();
        HVsync = 1'b1;
        tick();
    endtask

    task automatic read_px(input int n);
        HMemRead = 1'b1;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (PixEn !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            if (w >= 20) begin
                check("pix_timeout", 32'd0, 32'd1);
                HMemRead = 1'b0;
                return;
            end
            tick();
            tick();
            px[k] = HDMIdata;
        end
        HMemRead = 1'b0;
    endtask

    task automatic check_disp(input string tag, input int seed, input int n);
        read_px(n);
        for (int k = 0; k < n; k++) check(tag, 32'(px[k]), 32'(exp_px(pat(seed, k))));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; RecEn = 1'b1; RecValid = 1'b0; RecFrame = 1'b0;
        RecData = '0; RecAdd = '0; HVsync = 1'b1; HMemRead = 1'b0;
        #1;
        check("rst_outs", {FrameDone, FrameErr, DropFrm, AddrErr, PixEn}, 32'd0);
        check("rst_miss", 32'(MissCnt), 32'd0);
        check("rst_hdmi", 32'(HDMIdata), 32'd0);
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // 1: complete frame, swap on blanking, displayed with expansion
        send_range(0, 0, 15, 16'h0000);
        check("t1_done", 32'(FrameDone), 32'd1);
        check("t1_err", 32'(FrameErr), 32'd0);
        tick();
        check("t1_done_pulse", 32'(FrameDone), 32'd0);
        vblank();
        read_px(6);
        check("t1_px0", 32'(px[0]), 32'h0f0f0f);
        check("t1_px1", 32'(px[1]), 32'h1f1f1f);
        check("t1_px5", 32'(px[5]), 32'h5f5f5f);
        tick();
        check("t1_hold", 32'(HDMIdata), 32'h5f5f5f);
        tick();
        check("t1_zero", 32'(HDMIdata), 32'd0);

        // 2: addresses 3 and 7 missing
        send_range(1, 0, 15, 16'h0088);
        check("t2_err", 32'(FrameErr), 32'd1);
        check("t2_done", 32'(FrameDone), 32'd0);
        check("t2_miss", 32'(MissCnt), 32'd2);
        tick();
        check("t2_err_pulse", 32'(FrameErr), 32'd0);
        vblank();
        check_disp("t2_disp", 0, 4);

        // 3: back-to-back frames while Pending; second must be dropped
        send_range(2, 0, 15, 16'h0000);
        check("t3_done_a", 32'(FrameDone), 32'd1);
        send_range(3, 0, 0, 16'h0000);
        check("t3_drop", 32'(DropFrm), 32'd1);
        send_range(3, 1, 15, 16'h0000);
        check("t3_done_b", 32'(FrameDone), 32'd0);
        check("t3_err_b", 32'(FrameErr), 32'd0);
        vblank();
        check_disp("t3_disp", 2, 4);
        vblank();
        check_disp("t3_disp_again", 2, 4);

        // 4: out-of-range address inside an otherwise complete frame
        send_range(4, 0, 0, 16'h0000);
        check("t4_drop_clr", 32'(DropFrm), 32'd0);
        send(18, 12'hbad, 1'b0);
        check("t4_addr_err", 32'(AddrErr), 32'd1);
        send_range(4, 1, 15, 16'h0000);
        check("t4_done", 32'(FrameDone), 32'd1);
        check("t4_addr_sticky", 32'(AddrErr), 32'd1);
        vblank();
        check_disp("t4_disp", 4, 4);

        // 5: completion coincides with blanking, swap follows next cycle
        send_range(5, 0, 0, 16'h0000);
        check("t5_addr_clr", 32'(AddrErr), 32'd0);
        send_range(5, 1, 14, 16'h0000);
        HVsync = 1'b0;
        send(15, pat(5, 15), 1'b0);
        check("t5_done", 32'(FrameDone), 32'd1);
        tick();
        HVsync = 1'b1;
        send(2, 12'habc, 1'b0);
        check_disp("t5_disp", 5, 4);

        // 6: reset in the middle of a frame
        send_range(6, 0, 8, 16'h0000);
        check("t6_miss_held", 32'(MissCnt), 32'd2);
        RecValid = 1'b1; RecAdd = 16'd9; RecData = pat(6, 9);
        rstn = 1'b0;
        #1;
        check("t6_rst_miss", 32'(MissCnt), 32'd0);
        check("t6_rst_outs", {FrameDone, FrameErr, DropFrm, AddrErr, PixEn}, 32'd0);
        RecValid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check_disp("t6_pre_blank", 5, 4);
        send_range(7, 0, 15, 16'h0000);
        check("t6_done", 32'(FrameDone), 32'd1);
        vblank();
        check_disp("t6_disp", 7, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_mem.md
Name: rx_mem

Overview:
- Receive-side frame store; the counterpart of the camera-side transmit memory.
- Accepts 12-bit RGB444 words with frame addresses from the radio receiver and writes them into one of two ping-pong frame banks.
- Swaps banks only during vertical blanking, so the display never tears.
- Streams the display bank to the HDMI timing generator, one 24-bit pixel per pixel-enable.

Parameters:
DEPTH, 38400, words per frame (160x240 pixels); RecAdd values >= DEPTH are out of range.
AW, 16, address width; DEPTH <= 2**AW.
DIV, 5, Cclk cycles per pixel slot on the read side.

Ports:
Cclk  in  1  single system clock; all logic on rising edge.
rstn  in  1  asynchronous active-low reset.
RecEn  in  1  receiver link up; RecValid is ignored when low.
RecValid  in  1  one-cycle strobe: RecData/RecAdd valid.
RecData  in  12  pixel word {R[3:0],G[3:0],B[3:0]}.
RecAdd  in  AW  word address within frame.
RecFrame  in  1  qualifies RecValid: this word starts a new frame (RecAdd==0).
FrameDone  out  1  one-cycle pulse: complete frame accepted into write bank.
FrameErr  out  1  one-cycle pulse: frame ended with missing words.
MissCnt  out  AW  missing-word count of last errored frame (held).
DropFrm  out  1  current incoming frame is being discarded.
AddrErr  out  1  sticky: out-of-range address seen since last RecFrame.
HVsync  in  1  low = vertical blanking.
HMemRead  in  1  high = active pixel window; fetch one pixel per slot.
HDMIdata  out  24  {R,4'hf,G,4'hf,B,4'hf}; zero outside active window.
PixEn  out  1  one-cycle pulse per pixel slot (Cnt==0).

Behaviour:
- Reset: all outputs 0, MissCnt=0, WBank=0 (RBank=1), Pending=0, WCnt=0, Cnt=0, HRadd=0. Memory contents are undefined.
- Accept condition: Acc = RecEn && RecValid. No backpressure exists; the radio cannot stall.
- On Acc with RecFrame:
  - If Pending=1: DropFrm<=1.
  - Else: DropFrm<=0 and WCnt<=1.
  - In both cases AddrErr<=0.
- Write: on Acc && !DropFrm(next) && RecAdd<DEPTH, write bank[WBank][RecAdd] <= RecData.
  - If RecFrame=0, WCnt increments (saturating at DEPTH).
  - On Acc with RecAdd>=DEPTH: no write, no count; AddrErr<=1.
- Frame end: Acc && RecAdd==DEPTH-1 && !DropFrm. Using count including this word (C):
  - C==DEPTH: FrameDone pulse on the next cycle and Pending<=1.
  - Otherwise: FrameErr pulse on the next cycle, MissCnt<=DEPTH-C, Pending unchanged, and the bank is reused.
- Swap: on the cycle where Pending=1 and HVsync=0, WBank<=~WBank and Pending<=0.
  - Swap has priority over a same-cycle write: that write goes to the old WBank. This is legal because Pending blocks new frames.
- Duplicate writes to the same address overwrite the earlier value and still count. The count is a word count, not coverage.
- Read timing: Cnt runs 0..DIV-1 and wraps; PixEn=(Cnt==0) is registered.
  - HVsync=0: HRadd<=0.
  - PixEn && HMemRead: read bank[~WBank][HRadd]; HRadd<=HRadd+1, wrapping DEPTH-1 -> 0.
- Read latency: registered read data appears 1 cycle after the fetch; HDMIdata is registered 1 more cycle later. Total 2 Cclk after PixEn.
  - HDMIdata holds until the next fetch.
  - HDMIdata goes to 0 two cycles after HMemRead falls.
- Memory: two synchronous banks, or one 2*DEPTH array with bank bit as MSB. One write port, one read port.
- Reset mid-frame: Pending cleared and the partial frame is discarded. The first full frame after reset lands in bank 0 and is displayed after the next blanking.

Test Plan:
1. Reset, then DEPTH=16 words addresses 0..15 with RecFrame on word 0, data=addr*0x111 -> FrameDone pulse one cycle after word 15. After HVsync low then high, the HMemRead pixel-0 HDMIdata is 24'h0f0f0f, pixel 1 is 24'h1f1f1f (pixel 5 e.g. 24'h5f5f5f).
2. Frame with addresses 3 and 7 omitted -> FrameErr pulse, MissCnt=2, no FrameDone, Pending stays 0, display bank unchanged.
3. Two complete frames sent back-to-back with HVsync held high -> second frame has DropFrm=1 and no FrameDone. After HVsync low: swap occurs once and the first frame is displayed.
4. RecAdd=DEPTH+2 with RecValid -> no write, AddrErr=1 until the next RecFrame. The frame still completes if all 0..DEPTH-1 are present.
5. Same-cycle frame-end completion and HVsync low (Pending already 0) -> Pending set, then swap on the following cycle. Verify no write lands in the displayed bank.
6. Assert rstn low mid-frame at word 9 -> all outputs 0 asynchronously. Resend the full frame -> FrameDone, WBank toggles to 1 after blanking.
